instr_queue: RTL
================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving queue entry count; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port push_valid, input, 1 bit: the fetch stage offers an instruction.
REQ-005 SHALL have port push_ready, output, 1 bit: the queue accepts an offered instruction this cycle.
REQ-006 SHALL have ports push_instr, push_pc and push_pc2, inputs, 16 bits each: the fetched instruction, its PC, and PC+2.
REQ-007 SHALL have port flush, input, 1 bit: discard all entries (branch taken, jump or redirect).
REQ-008 SHALL have port pop_valid, output, 1 bit: the head entry is available to decode.
REQ-009 SHALL have port pop_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-010 SHALL have ports pop_instr, pop_pc and pop_pc2, outputs, 16 bits each: the head entry fields.
REQ-011 SHALL have port count, output, clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 SHALL operate as a FIFO storing {instr, pc, pc2} per entry, 48 bits.
REQ-013 SHALL define push_ready as NOT full; push_ready SHALL be a function of state only, never of push_valid.
REQ-014 SHALL define a push as push_valid AND push_ready AND NOT flush; a pushed entry is written at the tail and the tail pointer advances.
REQ-015 SHALL define pop_valid as NOT empty, except as modified by REQ-026.
REQ-016 SHALL define a pop as pop_valid AND pop_ready AND NOT flush; a pop advances the head pointer.
REQ-017 SHALL drive pop_instr = 16'h0800 (NOP), pop_pc = 0 and pop_pc2 = 0 when pop_valid = 0.
REQ-018 SHALL, when a push and a pop occur in the same cycle, leave count unchanged; this is legal at any non-full, non-empty occupancy.
REQ-019 SHALL wrap head and tail pointers modulo DEPTH; full/empty SHALL be distinguished using an extra pointer MSB, with no wasted entry.
REQ-020 SHALL ignore push_valid while full, dropping nothing internally; fetch is responsible for holding its PC.
REQ-021 SHALL ignore pop_ready while empty, with no underflow and no pointer change.
REQ-022 SHALL, when flush is high at an edge, set count = 0, set head = tail = 0, and drop any same-cycle push or pop.
REQ-023 SHALL give a latency of 1 cycle without bypass: an entry pushed at edge N is visible on the pop side after edge N.
REQ-024 SHALL update count on the clock edge together with the pointers; count equals tail minus head.

Reset
REQ-025 SHALL, while rst = 0, asynchronously clear head, tail and count to 0, which forces push_ready = 1 and pop_valid = 0 with NOP outputs; the storage array is not reset. Reset asserted mid-operation discards all entries.

Configuration
REQ-026 SHALL implement a bypass path, compiled in when macro INSTR_QUEUE_BYPASS_EN is defined:
- When the queue is empty, push_valid = 1 and flush = 0: pop_valid = 1 and pop_* = push_* combinationally in the same cycle.
- If pop_ready is also high, the entry is consumed and not stored, and count stays 0.
REQ-027 SHALL, when INSTR_QUEUE_BYPASS_EN is undefined, have no combinational path from push_* to pop_*.

Structure
REQ-028 SHALL place constants and types in shared package instr_queue_pkg: NOP_INSTR = 16'h0800, entry struct {instr, pc, pc2}, and ENTRY_W = 48.
REQ-029 SHALL implement storage as sub-module iq_storage: a DEPTH x ENTRY_W register array with one write port and one asynchronous read port, written only on push.

Verification
REQ-030 SHALL cover reset: assert rst = 0 mid-stream with 3 entries -> count = 0, pop_valid = 0, pop_instr = 16'h0800, push_ready = 1.
REQ-031 SHALL cover fill: DEPTH = 4, push 0x1111, 0x2222, 0x3333, 0x4444 with pop_ready = 0 -> count = 4, push_ready = 0, a 5th push is ignored; then pop 4 times -> order 0x1111..0x4444 and pc2 = pc + 2 each time.
REQ-032 SHALL cover simultaneous push/pop: at count = 2, push and pop for 10 cycles -> count stays 2, pointers wrap, data is in order.
REQ-033 SHALL cover flush: at count = 3, assert flush together with push_valid and pop_ready -> next cycle count = 0 and the pushed entry is absent.
REQ-034 SHALL cover bypass: empty queue, push 0xA5A5 at pc = 0x0010 with pop_ready = 1 -> with the macro, pop_instr = 0xA5A5 in the same cycle and count stays 0; without the macro, pop_valid = 0 that cycle and 0xA5A5 appears the next cycle.
REQ-035 SHALL cover empty pop: empty queue, pop_ready = 1 for 3 cycles -> count stays 0 and outputs remain NOP.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package instr_queue_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam int          ENTRY_W   = 48;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } entry_t;

    localparam entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: 16'h0000, pc2: 16'h0000};

endpackage

// File: rtl/iq_storage.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one asynchronous read port.
// Not reset; validity of each slot is tracked by the queue pointers.
module iq_storage
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  entry_t                     wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output entry_t                     rd_data
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode FIFO of {instr, pc, pc2}; 1-cycle latency, or 0 from empty with INSTR_QUEUE_BYPASS_EN.
// push_ready = not full (state only); flush empties the queue and drops same-cycle push/pop.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [15:0]              push_instr,
    input  logic [15:0]              push_pc,
    input  logic [15:0]              push_pc2,
    input  logic                     flush,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [15:0]              pop_instr,
    output logic [15:0]              pop_pc,
    output logic [15:0]              pop_pc2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Pointers carry one extra MSB so full and empty differ without a spare slot.
    logic [AW:0] head;
    logic [AW:0] tail;
    logic        empty;
    logic        full;
    logic        bypass;
    logic        push_fire;
    logic        pop_fire;
    entry_t      push_entry;
    entry_t      rd_entry;
    entry_t      out_entry;

    assign empty      = (head == tail);
    assign full       = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign push_ready = ~full;
    assign count      = tail - head;
    assign push_entry = '{instr: push_instr, pc: push_pc, pc2: push_pc2};

`ifdef INSTR_QUEUE_BYPASS_EN
    assign bypass = empty & push_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle is never stored.
    assign push_fire = push_valid & push_ready & ~flush & ~(bypass & pop_ready);
    assign pop_fire  = ~empty & pop_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_fire) tail <= tail + PTR_ONE;
            if (pop_fire)  head <= head + PTR_ONE;
        end
    end

    iq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en   (push_fire),
        .wr_addr (tail[AW-1:0]),
        .wr_data (push_entry),
        .rd_addr (head[AW-1:0]),
        .rd_data (rd_entry)
    );

    always_comb begin
        pop_valid = ~empty;
        out_entry = rd_entry;
        if (bypass) begin
            pop_valid = 1'b1;
            out_entry = push_entry;
        end
        if (!pop_valid) out_entry = NOP_ENTRY;
    end

    assign pop_instr = out_entry.instr;
    assign pop_pc    = out_entry.pc;
    assign pop_pc2   = out_entry.pc2;

endmodule
